// File: rtl/mig_pkg.sv
// Shared sizing defaults and constants for the operand fetch stage.
package mig_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int NREGS_DEF = 8;
  localparam int AW_DEF    = $clog2(NREGS_DEF);
  localparam int ZERO_REG  = 0;

endpackage

// File: rtl/op_regfile.sv
// Register file with two read ports and one write port; r0 is hardwired to zero.
// A write in flight is forwarded to both read ports in the same cycle.
module op_regfile
  import mig_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREGS = NREGS_DEF,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    rd_addr1,
  input  logic [AW-1:0]    rd_addr2,
  output logic [WIDTH-1:0] rd_data1,
  output logic [WIDTH-1:0] rd_data2,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data
);

  logic [WIDTH-1:0] regs [NREGS];
  logic             wr_hit;

  assign wr_hit = wr_en && (wr_addr != AW'(ZERO_REG));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_hit) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data1 = regs[rd_addr1];
    rd_data2 = regs[rd_addr2];
    if (wr_hit && (wr_addr == rd_addr1)) rd_data1 = wr_data;
    if (wr_hit && (wr_addr == rd_addr2)) rd_data2 = wr_data;
    if (rd_addr1 == AW'(ZERO_REG)) rd_data1 = '0;
    if (rd_addr2 == AW'(ZERO_REG)) rd_data2 = '0;
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads sources, blocks on pending destinations (scoreboard),
// and issues a registered payload to the executor.
module operand_fetch
  import mig_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREGS = NREGS_DEF,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    in_rs1,
  input  logic [AW-1:0]    in_rs2,
  input  logic [AW-1:0]    in_rd,
  input  logic             in_imm_sel,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] operand1,
  output logic [WIDTH-1:0] operand2,
  output logic [AW-1:0]    out_rd,
  output logic [15:0]      issue_count
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
  // valid must not depend on ready; payload stays stable while valid && !ready.

  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] rs2_data;
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;
  logic             wb_hit;
  logic             rs1_busy;
  logic             rs2_busy;
  logic             hazard;
  logic             accept;

  op_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .rd_addr1 (in_rs1),
    .rd_addr2 (in_rs2),
    .rd_data1 (rs1_data),
    .rd_data2 (rs2_data),
    .wr_en    (wb_en),
    .wr_addr  (wb_addr),
    .wr_data  (wb_data)
  );

  assign wb_hit = wb_en && (wb_addr != AW'(ZERO_REG));

  // A pending source is still usable when its result arrives this very cycle.
  assign rs1_busy = pending[in_rs1] && !(wb_hit && (wb_addr == in_rs1));
  assign rs2_busy = pending[in_rs2] && !(wb_hit && (wb_addr == in_rs2));
  assign hazard   = rs1_busy || (!in_imm_sel && rs2_busy);

  assign in_ready = !reset && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (accept && (in_rd != AW'(ZERO_REG))) set_mask[in_rd] = 1'b1;
    if (wb_hit) clr_mask[wb_addr] = 1'b1;
  end

  // Set wins over clear so a same-cycle reissue of the destination stays pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      operand1    <= '0;
      operand2    <= '0;
      out_rd      <= '0;
      issue_count <= '0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      operand1    <= rs1_data;
      operand2    <= in_imm_sel ? in_imm : rs2_data;
      out_rd      <= in_rd;
      issue_count <= issue_count + 16'd1;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus random traffic against a
// register/pending/queue reference model.
module tb_operand_fetch;

  localparam int W  = 32;
  localparam int NR = 8;
  localparam int AW = 3;
  localparam int PW = AW + 2 * W;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rs1, in_rs2, in_rd;
  logic          in_imm_sel;
  logic [W-1:0]  in_imm;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [W-1:0]  wb_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  operand1, operand2;
  logic [AW-1:0] out_rd;
  logic [15:0]   issue_count;

  operand_fetch #(.WIDTH(W), .NREGS(NR)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_rd       (in_rd),
    .in_imm_sel  (in_imm_sel),
    .in_imm      (in_imm),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .operand1    (operand1),
    .operand2    (operand2),
    .out_rd      (out_rd),
    .issue_count (issue_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  logic [W-1:0]  m_rf [NR];
  bit            m_pend [NR];
  logic [15:0]   m_cnt;
  logic [PW-1:0] exp_q [$];
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] rd_model(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (wb_en && wb_addr == a) return wb_data;
    return m_rf[a];
  endfunction

  function automatic logic busy(input logic [AW-1:0] a);
    return m_pend[a] && !(wb_en && wb_addr == a && a != 0);
  endfunction

  // one clock: check in_ready before the edge, advance the model, check outputs after
  task automatic step();
    logic [W-1:0] e1, e2;
    logic         hz, rdy;
    @(negedge clk);
    hz  = busy(in_rs1) || (!in_imm_sel && busy(in_rs2));
    rdy = !reset && !hz && (exp_q.size() == 0 || out_ready);
    chk("in_ready", in_ready, rdy);
    e1 = rd_model(in_rs1);
    e2 = in_imm_sel ? in_imm : rd_model(in_rs2);
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < NR; i++) begin
        m_rf[i] = '0;
        m_pend[i] = 0;
      end
      exp_q.delete();
      m_cnt = '0;
    end else begin
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (wb_en && wb_addr != 0) begin
        m_rf[wb_addr] = wb_data;
        m_pend[wb_addr] = 0;
      end
      if (in_valid && rdy) begin
        exp_q.push_back({in_rd, e2, e1});
        if (in_rd != 0) m_pend[in_rd] = 1;
        m_cnt = m_cnt + 16'd1;
      end
    end
    #1;
    chk("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) chk("payload", {out_rd, operand2, operand1}, exp_q[0]);
    chk("issue_count", issue_count, m_cnt);
  endtask

  // driver
  task automatic drive(input logic v, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                       input logic [AW-1:0] rd, input logic isel, input logic [W-1:0] imm,
                       input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                       input logic ordy);
    in_valid = v; in_rs1 = r1; in_rs2 = r2; in_rd = rd;
    in_imm_sel = isel; in_imm = imm;
    wb_en = we; wb_addr = wa; wb_data = wd;
    out_ready = ordy;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, '0, 0, 0, '0, 1);
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [PW-1:0] held;
    logic [15:0]   held_cnt;
    for (int i = 0; i < NR; i++) begin
      m_rf[i] = '0;
      m_pend[i] = 0;
    end
    m_cnt = '0;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, '0, 0, 0, '0, 1);

    // reset state
    do_reset();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_operand1", operand1, 32'h0);
    chk("rst_operand2", operand2, 32'h0);
    chk("rst_out_rd", out_rd, 3'd0);
    chk("rst_issue_count", issue_count, 16'h0);

    // writeback r3/r4, then read them
    drive(0, 0, 0, 0, 0, '0, 1, 3, 32'h10, 1); step();
    drive(0, 0, 0, 0, 0, '0, 1, 4, 32'h20, 1); step();
    drive(1, 3, 4, 5, 0, '0, 0, 0, '0, 1);     step();
    chk("basic_valid", out_valid, 1'b1);
    chk("basic_op1", operand1, 32'h10);
    chk("basic_op2", operand2, 32'h20);
    chk("basic_rd", out_rd, 3'd5);

    // RAW hazard on r5 released by a bypassed writeback
    drive(1, 5, 0, 6, 0, '0, 0, 0, '0, 1);
    step();
    chk("hazard_stall", in_ready, 1'b0);
    step();
    chk("hazard_stall2", in_ready, 1'b0);
    drive(1, 5, 0, 6, 0, '0, 1, 5, 32'hAB, 1);
    step();
    chk("bypass_valid", out_valid, 1'b1);
    chk("bypass_op1", operand1, 32'hAB);

    // downstream backpressure for 3 cycles
    held = exp_q[0];
    held_cnt = m_cnt;
    drive(1, 0, 0, 0, 0, '0, 0, 0, '0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_payload", {out_rd, operand2, operand1}, held);
      chk("stall_ready", in_ready, 1'b0);
      chk("stall_count", issue_count, held_cnt);
    end
    out_ready = 1'b1;
    step();

    // immediate operand, r0 source, writeback to r0 ignored
    drive(1, 0, 2, 0, 1, 32'hFFFF_FFFF, 1, 0, 32'hDEAD_BEEF, 1);
    step();
    chk("imm_op1", operand1, 32'h0);
    chk("imm_op2", operand2, 32'hFFFF_FFFF);
    drive(1, 0, 0, 0, 0, '0, 0, 0, '0, 1);
    step();
    chk("r0_read", operand2, 32'h0);

    // random traffic
    for (int n = 0; n < 500; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 1), $urandom_range(0, NR - 1), $urandom_range(0, NR - 1),
            $urandom_range(0, NR - 1), $urandom_range(0, 1), $urandom,
            $urandom_range(0, 1), $urandom_range(0, NR - 1), $urandom,
            $urandom_range(0, 3) != 0);
      step();
    end
    reset = 1'b0;

    // reset while an output is in flight and r2 is pending
    do_reset();
    drive(1, 0, 0, 2, 0, '0, 1, 2, 32'h55, 0); step();
    drive(0, 0, 0, 0, 0, '0, 0, 0, '0, 0);      step();
    chk("pre_rst_valid", out_valid, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_count", issue_count, 16'h0);
    drive(1, 2, 2, 0, 0, '0, 0, 0, '0, 1);
    step();
    chk("post_rst_valid", out_valid, 1'b1);
    chk("post_rst_r2", operand1, 32'h0);

    // issue counter wrap
    do_reset();
    drive(1, 0, 0, 0, 0, '0, 0, 0, '0, 1);
    for (int n = 0; n < 65537; n++) step();
    chk("count_wrap", issue_count, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
